spi_cfg_sequencer: RTL and testbench

Configuration sequencer and arbiter for the serial SPI configuration chain. Up to N_REQ on-chip requesters each submit a configuration word with a register-select flag. The block grants the chain to one requester at a time, round-robin, and shifts the word out MSB-first on SIN/clk with REGSEL held for the frame. It also owns the chain's global reset (GRST) sequencing after power-up reset.

---
 rtl/spi_cfg_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: round-robin arbiter and serialiser for the SPI configuration
// chain. After reset it holds the chain in global reset (GRST low) for GRST_HOLD
// cycles. It then grants one requester at a time and shifts that requester's
// captured word out MSB-first on SIN/clk, with REGSEL held for the whole frame.
//
// Requester handshake: a requester raises req[i] and keeps data_in/regsel_in
// valid until gnt[i] rises. The word and flag are captured on that grant edge,
// so later changes to req, data_in or regsel_in do not affect the frame.
// gnt[i] stays high for the whole frame. done[i] pulses for one cycle on the
// final cycle of the frame. A req that is still high afterwards is treated as a
// new request.
module spi_cfg_sequencer #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int CLK_DIV   = 2,
    parameter int GRST_HOLD = 16
) (
    input  logic                   SCLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       regsel_in,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   GRST,
    output logic                   SIN,
    output logic                   REGSEL,
    output logic                   clk,
    output logic [1:0]             state_dbg
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int BIT_W  = $clog2(WIDTH + 1);
    localparam int PH_W   = $clog2(2 * CLK_DIV + 1);
    localparam int HOLD_W = $clog2(GRST_HOLD + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(CLK_DIV);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GRST_HOLD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              busy_q, busy_d;
    logic              grst_q, grst_d;
    logic              sin_q, sin_d;
    logic              regsel_q, regsel_d;
    logic              clk_q, clk_d;

    logic [WIDTH-1:0]  word_arr [N_REQ];
    logic [WIDTH-1:0]  sel_word;
    logic [PTR_W-1:0]  pick;
    logic [PTR_W-1:0]  cand;
    logic              any_req;

    // Slice the flat data bus into one word per requester
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            word_arr[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: first requester at or after the pointer, with wrap-around.
    // The loop runs downward so that the candidate nearest the pointer wins.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (int'(ptr_q) + k >= N_REQ) begin
                cand = PTR_W'(int'(ptr_q) + k - N_REQ);
            end else begin
                cand = PTR_W'(int'(ptr_q) + k);
            end
            if (req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
        sel_word = word_arr[pick];
    end

    // Next-state and registered-output computation for the sequencer FSM
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        grst_d   = grst_q;
        sin_d    = sin_q;
        regsel_d = regsel_q;
        clk_d    = clk_q;

        case (state_q)
            S_INIT: begin
                grst_d   = 1'b0;
                gnt_d    = '0;
                sin_d    = 1'b0;
                regsel_d = 1'b0;
                clk_d    = 1'b0;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    grst_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            S_IDLE: begin
                gnt_d    = '0;
                sin_d    = 1'b0;
                regsel_d = 1'b0;
                clk_d    = 1'b0;
                phase_d  = '0;
                bit_d    = '0;
                if (any_req) begin
                    state_d     = S_SHIFT;
                    gnt_d[pick] = 1'b1;
                    sin_d       = sel_word[WIDTH-1];
                    shreg_d     = sel_word << 1;
                    regsel_d    = regsel_in[pick];
                    ptr_d       = (pick == PTR_LAST) ? '0 : pick + 1'b1;
                end
            end

            S_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    // End of one bit's high phase: present the next bit at the
                    // start of the following low phase, or leave after the LSB.
                    phase_d = '0;
                    clk_d   = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_GAP;
                        sin_d   = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sin_d   = shreg_q[WIDTH-1];
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    clk_d   = (phase_d >= PH_HIGH);
                end
            end

            S_GAP: begin
                clk_d = 1'b0;
                sin_d = 1'b0;
                if (phase_q == PH_LAST) begin
                    state_d  = S_IDLE;
                    gnt_d    = '0;
                    regsel_d = 1'b0;
                    phase_d  = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (phase_d == PH_LAST) begin
                        done_d = gnt_q;
                    end
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; asynchronous reset forces every output low
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_INIT;
            hold_q   <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            grst_q   <= 1'b0;
            sin_q    <= 1'b0;
            regsel_q <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            grst_q   <= grst_d;
            sin_q    <= sin_d;
            regsel_q <= regsel_d;
            clk_q    <= clk_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign GRST      = grst_q;
    assign SIN       = sin_q;
    assign REGSEL    = regsel_q;
    assign clk       = clk_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: default-parameter instance plus a
// small CLK_DIV=1/WIDTH=8 instance sharing the same clock and reset.
module tb_spi_cfg_sequencer;

    logic          SCLK = 1'b0;
    logic          RST  = 1'b0;

    logic [3:0]    req;
    logic [3:0]    regsel_in;
    logic [127:0]  data_in;
    logic [3:0]    gnt;
    logic [3:0]    done;
    logic          busy;
    logic          GRST;
    logic          SIN;
    logic          REGSEL;
    logic          clk;
    logic [1:0]    state_dbg;

    logic [1:0]    s_req;
    logic [1:0]    s_regsel;
    logic [15:0]   s_data;
    logic [1:0]    s_gnt;
    logic [1:0]    s_done;
    logic          s_busy;
    logic          s_GRST;
    logic          s_SIN;
    logic          s_REGSEL;
    logic          s_clk;
    logic [1:0]    s_state_dbg;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            g_c0   = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   rr_words [4];

    spi_cfg_sequencer dut (
        .SCLK      (SCLK),
        .RST       (RST),
        .req       (req),
        .regsel_in (regsel_in),
        .data_in   (data_in),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .GRST      (GRST),
        .SIN       (SIN),
        .REGSEL    (REGSEL),
        .clk       (clk),
        .state_dbg (state_dbg)
    );

    spi_cfg_sequencer #(
        .N_REQ     (2),
        .WIDTH     (8),
        .CLK_DIV   (1),
        .GRST_HOLD (4)
    ) dut_small (
        .SCLK      (SCLK),
        .RST       (RST),
        .req       (s_req),
        .regsel_in (s_regsel),
        .data_in   (s_data),
        .gnt       (s_gnt),
        .done      (s_done),
        .busy      (s_busy),
        .GRST      (s_GRST),
        .SIN       (s_SIN),
        .REGSEL    (s_REGSEL),
        .clk       (s_clk),
        .state_dbg (s_state_dbg)
    );

    // Clock and cycle counter
    always #5 SCLK = ~SCLK;
    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({gnt, done, busy, GRST, SIN, REGSEL, clk}), 32'h0);
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        data_in[idx*32 +: 32] = w;
    endtask

    // Count rising edges with RST low until GRST goes high; flag any activity
    // on the chain or grant outputs during the hold.
    task automatic watch_grst(input string tag);
        int k;
        int grst_edge;
        int bad;
        k = 0;
        grst_edge = 0;
        bad = 0;
        while (k < 40 && grst_edge == 0) begin
            @(negedge SCLK);
            k++;
            if (GRST === 1'b1) begin
                grst_edge = k;
            end else if (busy !== 1'b1 || clk !== 1'b0 || SIN !== 1'b0 ||
                         gnt !== 4'b0 || done !== 4'b0) begin
                bad++;
            end
        end
        check({tag, "_grst_edge"}, 32'(grst_edge), 32'd16);
        check({tag, "_hold_outputs"}, 32'(bad), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    // Follow one full frame of the default instance; expected word from exp_q
    task automatic watch_frame(input logic [3:0] exp_gnt, input logic exp_rs, input string tag);
        logic [31:0] exp_word;
        logic [31:0] word;
        logic        prev_clk;
        int          wait_n, n, rises, first_rise, last_rise, bad_gap, rs_bad, gnt_bad, c0;
        exp_word = 32'h0;
        if (exp_q.size() > 0) exp_word = exp_q.pop_front();
        wait_n = 0;
        while (gnt === 4'b0 && wait_n < 400) begin
            @(negedge SCLK);
            wait_n++;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_start"}, {28'b0, busy, clk, SIN, REGSEL},
              {28'b0, 1'b1, 1'b0, exp_word[31], exp_rs});
        c0 = cyc;
        g_c0 = c0;
        prev_clk = clk;
        word = 32'h0;
        n = 0; rises = 0; first_rise = 0; last_rise = 0;
        bad_gap = 0; rs_bad = 0; gnt_bad = 0;
        while (done === 4'b0 && n < 400) begin
            @(negedge SCLK);
            n++;
            if (clk === 1'b1 && prev_clk === 1'b0) begin
                rises++;
                word = {word[30:0], SIN};
                if (rises == 1) first_rise = cyc - c0;
                else if (cyc - last_rise != 4) bad_gap++;
                last_rise = cyc;
            end
            prev_clk = clk;
            if (REGSEL !== exp_rs) rs_bad++;
            if (gnt !== exp_gnt) gnt_bad++;
        end
        check({tag, "_done"}, 32'(done), 32'(exp_gnt));
        check({tag, "_len"}, 32'(cyc - c0), 32'd131);
        check({tag, "_rises"}, 32'(rises), 32'd32);
        check({tag, "_word"}, word, exp_word);
        check({tag, "_first_rise"}, 32'(first_rise), 32'd2);
        check({tag, "_clk_period"}, 32'(bad_gap), 32'd0);
        check({tag, "_regsel"}, 32'(rs_bad), 32'd0);
        check({tag, "_gnt_held"}, 32'(gnt_bad), 32'd0);
        @(negedge SCLK);
        check({tag, "_idle"}, 32'({gnt, done, busy, REGSEL, clk, SIN, GRST}), 32'd1);
    endtask

    initial begin
        int          n;
        int          c_prev;
        int          rises, first_rise, last_rise, bad_gap, c0;
        logic [7:0]  sword;
        logic        prev_clk;

        rr_words[0] = 32'h1122_3344;
        rr_words[1] = 32'h8000_0001;
        rr_words[2] = 32'hDEAD_BEEF;
        rr_words[3] = 32'h0F0F_F0F0;
        req = 4'b0; regsel_in = 4'b0; data_in = '0;
        s_req = 2'b0; s_regsel = 2'b0; s_data = 16'h0;

        // Power-up reset for 5 cycles
        #1 RST = 1'b1;
        repeat (5) @(negedge SCLK);
        check_all_zero("reset_outputs");
        check("reset_state", 32'(state_dbg), 32'd0);
        RST = 1'b0;
        watch_grst("pwr");
        check("small_grst", 32'(s_GRST), 32'd1);

        // Round-robin with all four requesting
        for (int i = 0; i < 4; i++) set_word(i, rr_words[i]);
        regsel_in = 4'b0101;
        req = 4'b1111;
        exp_q.push_back(rr_words[0]);
        exp_q.push_back(rr_words[1]);
        exp_q.push_back(rr_words[2]);
        exp_q.push_back(rr_words[3]);
        exp_q.push_back(rr_words[0]);
        watch_frame(4'b0001, 1'b1, "rr0");
        c_prev = g_c0;
        watch_frame(4'b0010, 1'b0, "rr1");
        check("rr_back_to_back", 32'(g_c0 - c_prev), 32'd133);
        watch_frame(4'b0100, 1'b1, "rr2");
        watch_frame(4'b1000, 1'b0, "rr3");
        fork
            watch_frame(4'b0001, 1'b1, "rr4");
            begin
                repeat (3) @(negedge SCLK);
                req = 4'b0;
            end
        join

        // Single frame from requester 1
        set_word(1, 32'hA5A5_0F0F);
        regsel_in = 4'b0010;
        req = 4'b0010;
        exp_q.push_back(32'hA5A5_0F0F);
        fork
            watch_frame(4'b0010, 1'b1, "single");
            begin
                repeat (3) @(negedge SCLK);
                req = 4'b0;
            end
        join

        // Captured word survives data/regsel/req changes after grant
        set_word(0, 32'h1234_5678);
        regsel_in = 4'b0000;
        req = 4'b0001;
        exp_q.push_back(32'h1234_5678);
        fork
            watch_frame(4'b0001, 1'b0, "stable");
            begin
                repeat (40) @(negedge SCLK);
                set_word(0, 32'hFFFF_0000);
                regsel_in[0] = 1'b1;
                req = 4'b0;
            end
        join

        // Reset in the middle of a frame
        set_word(3, 32'hCAFE_F00D);
        req = 4'b1000;
        n = 0;
        while (gnt === 4'b0 && n < 10) begin
            @(negedge SCLK);
            n++;
        end
        check("mid_gnt", 32'(gnt), 32'h8);
        repeat (42) @(negedge SCLK);
        #2 RST = 1'b1;
        #1;
        check_all_zero("mid_async");
        check("mid_state", 32'(state_dbg), 32'd0);
        req = 4'b0100;
        set_word(2, 32'h5A5A_C3C3);
        regsel_in = 4'b0100;
        repeat (3) @(negedge SCLK);
        check_all_zero("mid_held");
        RST = 1'b0;
        watch_grst("post");
        exp_q.push_back(32'h5A5A_C3C3);
        fork
            watch_frame(4'b0100, 1'b1, "post_frame");
            begin
                repeat (3) @(negedge SCLK);
                req = 4'b0;
            end
        join

        // Small instance: CLK_DIV=1, WIDTH=8, word 0x81
        s_data = 16'h0081;
        s_regsel = 2'b01;
        s_req = 2'b01;
        n = 0;
        while (s_gnt === 2'b0 && n < 20) begin
            @(negedge SCLK);
            n++;
        end
        s_req = 2'b0;
        check("sweep_gnt", 32'(s_gnt), 32'd1);
        check("sweep_start", 32'({s_busy, s_clk, s_SIN, s_REGSEL}), 32'hB);
        c0 = cyc;
        prev_clk = s_clk;
        sword = 8'h0;
        rises = 0; first_rise = 0; last_rise = 0; bad_gap = 0; n = 0;
        while (s_done === 2'b0 && n < 100) begin
            @(negedge SCLK);
            n++;
            if (s_clk === 1'b1 && prev_clk === 1'b0) begin
                rises++;
                sword = {sword[6:0], s_SIN};
                if (rises == 1) first_rise = cyc - c0;
                else if (cyc - last_rise != 2) bad_gap++;
                last_rise = cyc;
            end
            prev_clk = s_clk;
        end
        check("sweep_done", 32'(s_done), 32'd1);
        check("sweep_len", 32'(cyc - c0), 32'd17);
        check("sweep_rises", 32'(rises), 32'd8);
        check("sweep_word", 32'(sword), 32'h81);
        check("sweep_first_rise", 32'(first_rise), 32'd1);
        check("sweep_clk_period", 32'(bad_gap), 32'd0);
        @(negedge SCLK);
        check("sweep_idle", 32'({s_gnt, s_done, s_busy, s_REGSEL, s_clk, s_SIN, s_GRST}), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
